// File: rtl/sr_ff_pkg.sv
// Shared types for the SR flip-flop slice: conflict policy enum and the
// {s,r} command encoding used by every cell.
package sr_ff_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SET    = 2'd1,
    RESET  = 2'd2,
    TOGGLE = 2'd3
  } sr_policy_e;

  // Command word is {s, r}
  localparam logic [1:0] CMD_HOLD     = 2'b00;
  localparam logic [1:0] CMD_SET      = 2'b10;
  localparam logic [1:0] CMD_RESET    = 2'b01;
  localparam logic [1:0] CMD_CONFLICT = 2'b11;

endpackage

// File: rtl/sr_ff_cell.sv
// One SR storage bit: command decode, gated set/reset outputs, state register
// and, when SR_FF_CONFLICT_FLAG_EN is defined, a sticky conflict flag.
module sr_ff_cell
  import sr_ff_pkg::*;
#(
  parameter sr_policy_e POLICY = HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qbar,
  output logic sg,
  output logic rg
`ifdef SR_FF_CONFLICT_FLAG_EN
  ,
  output logic conflict
`endif
);

  logic [1:0] cmd;
  logic       q_q;
  logic       q_d;

  assign cmd = {s, r};

  always_comb begin
    sg = 1'b0;
    rg = 1'b0;
    case (cmd)
      CMD_HOLD:  ;
      CMD_SET:   sg = 1'b1;
      CMD_RESET: rg = 1'b1;
      CMD_CONFLICT: begin
        case (POLICY)
          SET:     sg = 1'b1;
          RESET:   rg = 1'b1;
          TOGGLE: begin
            sg = ~q_q;
            rg = q_q;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    q_d = sg | (q_q & ~rg);
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q    = q_q;
  assign qbar = ~q_q;

`ifdef SR_FF_CONFLICT_FLAG_EN
  logic conflict_q;
  logic conflict_d;

  always_comb begin
    conflict_d = conflict_q | (cmd == CMD_CONFLICT);
  end

  always_ff @(posedge clk) begin
    if (rst) conflict_q <= 1'b0;
    else     conflict_q <= conflict_d;
  end

  assign conflict = conflict_q;
`endif

endmodule

// File: rtl/sr_flip_flop.sv
// WIDTH independent clocked SR bits with observable gated commands.
// Define SR_FF_CONFLICT_FLAG_EN to add the sticky per-bit conflict output.
module sr_flip_flop
  import sr_ff_pkg::*;
#(
  parameter int         WIDTH           = 1,
  parameter sr_policy_e CONFLICT_POLICY = HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] sg,
  output logic [WIDTH-1:0] rg
`ifdef SR_FF_CONFLICT_FLAG_EN
  ,
  output logic [WIDTH-1:0] conflict
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_ff_cell #(
      .POLICY(CONFLICT_POLICY)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .s    (s[i]),
      .r    (r[i]),
      .q    (q[i]),
      .qbar (qbar[i]),
      .sg   (sg[i]),
      .rg   (rg[i])
`ifdef SR_FF_CONFLICT_FLAG_EN
      ,
      .conflict(conflict[i])
`endif
    );
  end

endmodule

// File: tb/tb_sr_flip_flop.sv
// Bench for sr_flip_flop: four 4-bit instances, one per conflict policy,
// driven by shared directed then random s/r/rst and checked via a scoreboard.
module tb_sr_flip_flop;
  import sr_ff_pkg::*;

  localparam int W  = 4;
  localparam int FW = 5 * W;

  logic clk;
  logic rst;
  logic [W-1:0] s;
  logic [W-1:0] r;

  logic [W-1:0] q_o    [4];
  logic [W-1:0] qbar_o [4];
  logic [W-1:0] sg_o   [4];
  logic [W-1:0] rg_o   [4];
  logic [W-1:0] conf_o [4];

  logic [4*FW-1:0] exp_q[$];

  logic [W-1:0] m_q    [4];
  logic [W-1:0] m_conf [4];

  int n_compared;
  int n_failed;
  string pname [4] = '{"hold", "set", "reset", "toggle"};

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sr_flip_flop #(.WIDTH(W), .CONFLICT_POLICY(HOLD)) u_hold (
    .clk(clk), .rst(rst), .s(s), .r(r),
    .q(q_o[0]), .qbar(qbar_o[0]), .sg(sg_o[0]), .rg(rg_o[0])
`ifdef SR_FF_CONFLICT_FLAG_EN
    , .conflict(conf_o[0])
`endif
  );

  sr_flip_flop #(.WIDTH(W), .CONFLICT_POLICY(SET)) u_set (
    .clk(clk), .rst(rst), .s(s), .r(r),
    .q(q_o[1]), .qbar(qbar_o[1]), .sg(sg_o[1]), .rg(rg_o[1])
`ifdef SR_FF_CONFLICT_FLAG_EN
    , .conflict(conf_o[1])
`endif
  );

  sr_flip_flop #(.WIDTH(W), .CONFLICT_POLICY(RESET)) u_reset (
    .clk(clk), .rst(rst), .s(s), .r(r),
    .q(q_o[2]), .qbar(qbar_o[2]), .sg(sg_o[2]), .rg(rg_o[2])
`ifdef SR_FF_CONFLICT_FLAG_EN
    , .conflict(conf_o[2])
`endif
  );

  sr_flip_flop #(.WIDTH(W), .CONFLICT_POLICY(TOGGLE)) u_toggle (
    .clk(clk), .rst(rst), .s(s), .r(r),
    .q(q_o[3]), .qbar(qbar_o[3]), .sg(sg_o[3]), .rg(rg_o[3])
`ifdef SR_FF_CONFLICT_FLAG_EN
    , .conflict(conf_o[3])
`endif
  );

`ifndef SR_FF_CONFLICT_FLAG_EN
  initial for (int p = 0; p < 4; p++) conf_o[p] = '0;
`endif

  // Reference: returns {sg, rg} from the command table; p indexes the policy.
  function automatic logic [1:0] ref_cmd(input int p, input logic sb,
                                         input logic rb, input logic qb);
    if (sb && rb) begin
      case (p)
        1:       return 2'b10;
        2:       return 2'b01;
        3:       return {~qb, qb};
        default: return 2'b00;
      endcase
    end
    return {sb, rb};
  endfunction

  // Driver: applies one command just after an edge and records what the
  // outputs must show for the rest of that cycle.
  task automatic apply(input logic rst_v, input logic [W-1:0] s_v,
                       input logic [W-1:0] r_v);
    logic [4*FW-1:0] e;
    logic [W-1:0] sgv, rgv, nq;
    logic [1:0] g;
    @(posedge clk);
    #1;
    rst = rst_v;
    s   = s_v;
    r   = r_v;
    e   = '0;
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < W; b++) begin
        g      = ref_cmd(p, s_v[b], r_v[b], m_q[p][b]);
        sgv[b] = g[1];
        rgv[b] = g[0];
        if (g[1])      nq[b] = 1'b1;
        else if (g[0]) nq[b] = 1'b0;
        else           nq[b] = m_q[p][b];
      end
      e[p*FW +: FW] = {m_q[p], ~m_q[p], sgv, rgv, m_conf[p]};
      if (rst_v) begin
        m_q[p]    = '0;
        m_conf[p] = '0;
      end else begin
        m_q[p]    = nq;
        m_conf[p] = m_conf[p] | (s_v & r_v);
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [4*FW-1:0] e;
    logic [FW-1:0] act, want, mask;
`ifdef SR_FF_CONFLICT_FLAG_EN
    mask = '1;
`else
    mask = {{(FW-W){1'b1}}, {W{1'b0}}};
`endif
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int p = 0; p < 4; p++) begin
        act  = {q_o[p], qbar_o[p], sg_o[p], rg_o[p], conf_o[p]} & mask;
        want = e[p*FW +: FW] & mask;
        n_compared++;
        if (act !== want) begin
          n_failed++;
          $display("FAIL %s q/qbar/sg/rg/conflict @%0t: got %h expected %h",
                   pname[p], $time, act, want);
        end
      end
    end
  end

  initial begin
    n_compared = 0;
    n_failed   = 0;
    rst = 1'b1;
    s   = '0;
    r   = '0;
    repeat (2) @(posedge clk);
    for (int p = 0; p < 4; p++) begin
      m_q[p]    = '0;
      m_conf[p] = '0;
    end

    // reset with set requested: decode visible, state stays 0
    apply(1'b1, 4'b0001, 4'b0000);
    // basic sequence, then repeated conflict from q=1
    apply(1'b0, 4'b0000, 4'b0000);
    apply(1'b0, 4'b0000, 4'b1111);
    apply(1'b0, 4'b1111, 4'b0000);
    apply(1'b0, 4'b1111, 4'b1111);
    apply(1'b0, 4'b1111, 4'b1111);
    apply(1'b0, 4'b1111, 4'b1111);
    // conflict flag persists through later commands, then reset clears it
    apply(1'b0, 4'b0000, 4'b0000);
    apply(1'b0, 4'b1111, 4'b0000);
    apply(1'b1, 4'b0000, 4'b0000);
    // multi-bit mix from q=0000
    apply(1'b0, 4'b1010, 4'b0110);
    apply(1'b0, 4'b0000, 4'b0000);
    // mid-operation reset with set held
    apply(1'b0, 4'b1111, 4'b0000);
    apply(1'b1, 4'b1111, 4'b0000);
    apply(1'b0, 4'b1111, 4'b0000);
    apply(1'b0, 4'b0000, 4'b0000);

    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 15) == 0),
            W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    end
    apply(1'b0, 4'b0000, 4'b0000);

    repeat (3) @(posedge clk);
    n_compared++;
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
